mem_ctrl: RTL and testbench

Arbiter and sequencer for the single byte-wide external memory bus (mem_a / mem_dout / mem_wr / mem_din). It shares the bus between instruction fetch (4-byte reads) and the load/store buffer (1/2/4-byte reads and writes). Each access is split into byte transfers, the 1-cycle read latency is absorbed, and I/O writes are stalled on io_buffer_full. Sits between IF, Lsb and the cpu top-level memory pins, replacing the combinational bus mux.

---
 rtl/mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide memory bus arbiter and sequencer shared by instruction fetch and the LSB.
//   clk_in, rst_in (sync, active high), rdy_in (pause), clear (flush from rob)
//   mem_din/mem_dout/mem_a/mem_wr: external byte bus; mem_din answers last cycle's mem_a
//   io_buffer_full: stalls writes into the I/O space (addr[17:16] == IO_TAG)
//   if_req/if_addr -> if_done/if_data: 4-byte little-endian fetch
//   lsb_req/lsb_wr/lsb_len/lsb_addr/lsb_wdata -> lsb_done/lsb_rdata: 1/2/4-byte load or store
//   busy: controller is not idle
//   Build option MEM_CTRL_RR_ARB_EN: round-robin arbitration instead of fixed LSB priority.
module mem_ctrl #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_TAG     = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  lsb_req,
    input  logic                  lsb_wr,
    input  logic [1:0]            lsb_len,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [31:0]           lsb_wdata,
    output logic                  lsb_done,
    output logic [31:0]           lsb_rdata,
    output logic                  busy
);
    typedef enum logic [1:0] {S_IDLE, S_IF, S_LR, S_LW} state_t;

    state_t                r_state, w_state_nx;
    logic [ADDR_WIDTH-1:0] r_addr, r_mem_a, w_addr;
    logic [31:0]           r_wd, r_buf, r_if_data, r_lsb_rdata, w_wd, w_buf_nx;
    logic [7:0]            r_mem_dout;
    logic [2:0]            r_n, r_cnt, r_cap, w_n, w_cnt, w_lsb_n;
    logic                  r_rd_act, r_rd_pend, r_mem_wr, r_if_done, r_lsb_done, r_busy;
    logic                  w_idle, w_rd_st, w_pick_lsb, w_grant, w_abort, w_wr, w_stall;
    logic                  w_issue, w_fin_rd, w_fin_wr;

`ifdef MEM_CTRL_RR_ARB_EN
    logic r_last_lsb;
    assign w_pick_lsb = lsb_req & ~(if_req & r_last_lsb);
`else
    assign w_pick_lsb = lsb_req;
`endif

    assign w_idle   = r_state == S_IDLE;
    assign w_rd_st  = r_state == S_IF || r_state == S_LR;
    assign w_grant  = w_idle & rdy_in & ~clear & ~r_if_done & ~r_lsb_done & (lsb_req | if_req);
    assign w_abort  = rdy_in & clear & w_rd_st;
    assign w_lsb_n  = (lsb_len == 2'd0) ? 3'd1 : (lsb_len == 2'd1) ? 3'd2 : 3'd4;
    // In IDLE the issue path works on the live request so byte 0 goes out on the grant edge
    assign w_addr   = w_idle ? (w_pick_lsb ? lsb_addr : if_addr) : r_addr;
    assign w_wd     = w_idle ? lsb_wdata : r_wd;
    assign w_n      = w_idle ? (w_pick_lsb ? w_lsb_n : 3'd4) : r_n;
    assign w_cnt    = w_idle ? 3'd0 : r_cnt;
    assign w_wr     = w_idle ? (w_pick_lsb & lsb_wr) : r_state == S_LW;
    assign w_stall  = w_wr & (w_addr[17:16] == IO_TAG) & io_buffer_full;
    assign w_issue  = rdy_in & (w_idle ? w_grant : ~w_abort) & (w_cnt < w_n) & ~w_stall;
    // Last lane may arrive on this edge (rd_pend) or may already have landed during a pause
    assign w_fin_rd = rdy_in & w_rd_st & ~clear & (r_cap == r_n || (r_rd_pend && r_cap + 3'd1 == r_n));
    // Writes finish one bubble cycle (mem_wr low) after the last byte
    assign w_fin_wr = rdy_in & (r_state == S_LW) & (r_cnt == r_n + 3'd1);

    always_comb begin
        w_buf_nx = r_buf;
        if (r_rd_pend) w_buf_nx[{r_cap[1:0], 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = !rdy_in ? r_state :
                     w_idle  ? (w_grant ? (w_pick_lsb ? (lsb_wr ? S_LW : S_LR) : S_IF) : S_IDLE) :
                     (w_abort | w_fin_rd | w_fin_wr) ? S_IDLE : r_state;
    end

    always_comb begin
        mem_a     = r_mem_a;
        mem_dout  = r_mem_dout;
        mem_wr    = r_mem_wr & rdy_in;
        if_done   = r_if_done;
        if_data   = r_if_data;
        lsb_done  = r_lsb_done;
        lsb_rdata = r_lsb_rdata;
        busy      = r_busy;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_addr      <= '0;
            r_wd        <= '0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_cap       <= '0;
            r_buf       <= '0;
            r_rd_act    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_mem_a     <= '0;
            r_mem_dout  <= '0;
            r_mem_wr    <= 1'b0;
            r_if_done   <= 1'b0;
            r_if_data   <= '0;
            r_lsb_done  <= 1'b0;
            r_lsb_rdata <= '0;
            r_busy      <= 1'b0;
`ifdef MEM_CTRL_RR_ARB_EN
            r_last_lsb  <= 1'b0;
`endif
        end else begin
            // Capture runs even while paused so byte lanes never shift
            r_rd_pend <= r_rd_act & rdy_in & ~w_abort;
            if (r_rd_pend) begin
                r_buf <= w_buf_nx;
                r_cap <= r_cap + 3'd1;
            end
            if (rdy_in) begin
                r_busy     <= w_state_nx != S_IDLE;
                r_mem_wr   <= w_issue & w_wr;
                r_rd_act   <= w_issue & ~w_wr;
                r_if_done  <= w_fin_rd & (r_state == S_IF);
                r_lsb_done <= (w_fin_rd & (r_state == S_LR)) | w_fin_wr;
                r_cnt      <= (w_issue || (w_wr && w_cnt == w_n)) ? w_cnt + 3'd1 : w_cnt;
                if (w_fin_rd && r_state == S_IF) r_if_data <= w_buf_nx;
                if (w_fin_rd && r_state == S_LR) r_lsb_rdata <= w_buf_nx;
`ifdef MEM_CTRL_RR_ARB_EN
                if (w_fin_rd || w_fin_wr) r_last_lsb <= r_state != S_IF;
`endif
                if (w_issue) begin
                    r_mem_a <= w_addr + ADDR_WIDTH'(w_cnt);
                    if (w_wr) r_mem_dout <= w_wd[{w_cnt[1:0], 3'b000} +: 8];
                end
                if (w_grant) begin
                    r_addr <= w_addr;
                    r_wd   <= w_wd;
                    r_n    <= w_n;
                    r_buf  <= '0;
                    r_cap  <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed table-driven bench for mem_ctrl against a byte memory model.
module tb_mem_ctrl;
    logic        clk_in = 1'b0, rst_in, rdy_in, clear, io_buffer_full;
    logic        if_req, lsb_req, lsb_wr;
    logic [1:0]  lsb_len;
    logic [31:0] if_addr, lsb_addr, lsb_wdata;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a, if_data, lsb_rdata;
    logic        mem_wr, if_done, lsb_done, busy;

    int tests = 0, fails = 0, wr_total = 0;
    logic [7:0] mem [0:262143];

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        mem_din <= mem[mem_a[17:0]];
        if (mem_wr) begin
            mem[mem_a[17:0]] = mem_dout;
            wr_total++;
        end
    end

    typedef struct {
        bit          lsb;
        bit          wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wd;
        int          pause_at;
        int          pause_len;
        int          io_cyc;
        int          clear_at;
        bit          exp_done;
        int          exp_lat;
        logic [31:0] exp_data;
        int          exp_wrs;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {mem[18'(a + 3)], mem[18'(a + 2)], mem[18'(a + 1)], mem[18'(a)]};
    endfunction

    task automatic run(input int idx, input vec_t v);
        int          lat, other, w0;
        logic [31:0] data;
        lat = -1;
        other = 0;
        data = '0;
        w0 = wr_total;
        if_addr = v.addr;
        lsb_addr = v.addr;
        lsb_wr = v.wr;
        lsb_len = v.len;
        lsb_wdata = v.wd;
        if (v.io_cyc > 0) io_buffer_full = 1'b1;
        if (v.lsb) lsb_req = 1'b1;
        else if_req = 1'b1;
        for (int k = 0; k < 16 && lat < 0; k++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (k == 0) chk($sformatf("v%0d busy", idx), {31'b0, busy}, 32'd1);
            if (v.lsb ? lsb_done : if_done) begin
                lat = k;
                data = v.lsb ? lsb_rdata : if_data;
                if_req = 1'b0;
                lsb_req = 1'b0;
            end
            if (v.lsb ? if_done : lsb_done) other++;
            if (k == v.io_cyc - 1) io_buffer_full = 1'b0;
            if (k == v.pause_at) rdy_in = 1'b0;
            if (k == v.pause_at + v.pause_len) rdy_in = 1'b1;
            if (k == v.clear_at) begin
                clear = 1'b1;
                if (!v.exp_done) begin
                    if_req = 1'b0;
                    lsb_req = 1'b0;
                end
            end
            if (k == v.clear_at + 1) clear = 1'b0;
        end
        if_req = 1'b0;
        lsb_req = 1'b0;
        clear = 1'b0;
        @(negedge clk_in);
        if (v.exp_done) begin
            chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
            if (v.wr) chk($sformatf("v%0d mem", idx), rd_word(v.addr), v.exp_data);
            else chk($sformatf("v%0d data", idx), data, v.exp_data);
        end else begin
            chk($sformatf("v%0d no done", idx), lat, -1);
            chk($sformatf("v%0d idle busy", idx), {31'b0, busy}, 32'd0);
        end
        chk($sformatf("v%0d other done", idx), other, 0);
        chk($sformatf("v%0d writes", idx), wr_total - w0, v.exp_wrs);
    endtask

    task automatic pair();
        int lf, li, both;
        lf = -1;
        li = -1;
        both = 0;
        if_addr = 32'h100;
        lsb_addr = 32'h101;
        lsb_wr = 1'b0;
        lsb_len = 2'd0;
        if_req = 1'b1;
        lsb_req = 1'b1;
        for (int k = 0; k < 20 && (lf < 0 || li < 0); k++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (if_done && lsb_done) both++;
            if (if_done && lf < 0) begin
                lf = k;
                chk("pair if_data", if_data, 32'h00000513);
                if_req = 1'b0;
            end
            if (lsb_done && li < 0) begin
                li = k;
                chk("pair lsb_rdata", lsb_rdata, 32'h00000005);
                lsb_req = 1'b0;
            end
        end
        if_req = 1'b0;
        lsb_req = 1'b0;
        @(negedge clk_in);
        chk("pair both done", both, 0);
`ifdef MEM_CTRL_RR_ARB_EN
        chk("pair if cycle", lf, 5);
        chk("pair lsb cycle", li, 9);
`else
        chk("pair lsb cycle", li, 2);
        chk("pair if cycle", lf, 9);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
        mem[18'h100] = 8'h13; mem[18'h101] = 8'h05;
        mem[18'h204] = 8'hFE; mem[18'h205] = 8'hFF;
        mem[18'h3FFFE] = 8'h77; mem[18'h3FFFF] = 8'h66;
        mem[18'h0] = 8'h55; mem[18'h1] = 8'h44;
        //          lsb  wr   len   addr           wdata          pa  pl io  clr done lat data           wrs
        tbl[0]  = '{1'b0, 1'b0, 2'd0, 32'h100,      32'h0,         -1, 0, 0, -1, 1'b1, 5, 32'h00000513, 0};
        tbl[1]  = '{1'b1, 1'b1, 2'd3, 32'h200,      32'h11223344,  -1, 0, 0, -1, 1'b1, 5, 32'h11223344, 4};
        tbl[2]  = '{1'b1, 1'b0, 2'd3, 32'h200,      32'h0,         -1, 0, 0, -1, 1'b1, 5, 32'h11223344, 0};
        tbl[3]  = '{1'b1, 1'b0, 2'd0, 32'h203,      32'h0,         -1, 0, 0, -1, 1'b1, 2, 32'h00000011, 0};
        tbl[4]  = '{1'b1, 1'b0, 2'd1, 32'h204,      32'h0,          1, 2, 0, -1, 1'b1, 5, 32'h0000FFFE, 0};
        tbl[5]  = '{1'b1, 1'b0, 2'd2, 32'h200,      32'h0,         -1, 0, 0, -1, 1'b1, 5, 32'h11223344, 0};
        tbl[6]  = '{1'b1, 1'b1, 2'd0, 32'h210,      32'hDEADBEA5,  -1, 0, 0, -1, 1'b1, 2, 32'h000000A5, 1};
        tbl[7]  = '{1'b1, 1'b1, 2'd1, 32'h220,      32'h1234BEEF,  -1, 0, 0, -1, 1'b1, 3, 32'h0000BEEF, 2};
        tbl[8]  = '{1'b1, 1'b1, 2'd0, 32'h30000,    32'h00000041,  -1, 0, 3, -1, 1'b1, 5, 32'h00000041, 1};
        tbl[9]  = '{1'b1, 1'b1, 2'd3, 32'h240,      32'hCAFEF00D,   1, 2, 0, -1, 1'b1, 7, 32'hCAFEF00D, 4};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 32'hFFFFFFFE, 32'h0,         -1, 0, 0, -1, 1'b1, 5, 32'h44556677, 0};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 32'h100,      32'h0,         -1, 0, 0,  2, 1'b0, 0, 32'h0,        0};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 32'h100,      32'h0,         -1, 0, 0, -1, 1'b1, 5, 32'h00000513, 0};
        tbl[13] = '{1'b1, 1'b1, 2'd3, 32'h250,      32'h89ABCDEF,  -1, 0, 0,  1, 1'b1, 5, 32'h89ABCDEF, 4};
        tbl[14] = '{1'b1, 1'b1, 2'd0, 32'h200,      32'h00000099,  -1, 0, 3, -1, 1'b1, 2, 32'h11223399, 1};
        rst_in = 1'b1;
        rdy_in = 1'b1;
        clear = 1'b0;
        io_buffer_full = 1'b0;
        if_req = 1'b0;
        lsb_req = 1'b0;
        lsb_wr = 1'b0;
        lsb_len = 2'd0;
        if_addr = '0;
        lsb_addr = '0;
        lsb_wdata = '0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst mem_a", mem_a, 32'h0);
        chk("rst mem_dout/wr", {23'b0, mem_dout, mem_wr}, 32'h0);
        chk("rst dones/busy", {29'b0, if_done, lsb_done, busy}, 32'h0);
        chk("rst if_data", if_data, 32'h0);
        chk("rst lsb_rdata", lsb_rdata, 32'h0);
        rst_in = 1'b0;
        @(negedge clk_in);
        for (int i = 0; i < 15; i++) run(i, tbl[i]);
        pair();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
